fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch stage and IF/ID pipeline register.
- Sits directly upstream of the control unit, which decodes the 4-bit opcode this stage presents.
- Owns the PC and the next-PC selection (sequential, branch, jump, jr).
- Runs the request/ready handshake to instruction memory, honours hazard stalls and inserts NOP bubbles on redirects.

Parameters:
- PC_W, 8: PC / instruction-address width in words.
- INST_W, 16: instruction width; opcode is the top 4 bits.
- RESET_PC, 0: PC value loaded on reset.
- NOP_INST, 16'hF000: bubble encoding; its opcode field decodes as NOP in the shared ISA defines.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- br_taken  in  1  EX-stage branch resolved taken.
- br_target  in  PC_W  branch target.
- jump  in  1  ID-stage jump/jal.
- jump_target  in  PC_W  jump target.
- jr  in  1  ID-stage jr.
- jr_target  in  PC_W  register target.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  INST_W  fetched instruction.
- if_id_inst  out  INST_W  registered instruction to decode.
- if_id_pc1  out  PC_W  registered PC+1 of that instruction; jal link value.
- if_id_valid  out  1  if_id_inst is a real fetched instruction.
- if_id_opcode  out  4  if_id_inst[INST_W-1 -: 4]; feeds control unit inst input.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-low via rst_n.
- Reset values (rst_n=0 at posedge):
  - pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC.
  - if_id_inst=NOP_INST, if_id_pc1=0, if_id_valid=0.
  - buffer empty, discard=0.
  - Reset mid-handshake abandons the request; any later imem_ready is ignored while in IDLE.
- States:
  - IDLE: imem_req=0; unconditionally -> REQ next cycle, giving one bubble after reset.
  - REQ: imem_req=1, imem_addr=pc. imem_addr and imem_req are held stable until imem_ready=1.
    - On imem_ready with discard=0, no redirect, stall=0: if_id_inst<=imem_rdata, if_id_pc1<=pc+1, if_id_valid<=1, pc<=pc+1; stay REQ.
    - Same with stall=1: buffer<=imem_rdata, pc<=pc+1, IF/ID unchanged -> HOLD.
    - On imem_ready with discard=1: response dropped, discard<=0, stay REQ (new address issued next cycle).
  - HOLD: imem_req=0. When stall=0: IF/ID <= buffer, valid=1, buffer emptied -> REQ.
- Throughput and latency:
  - Zero-wait memory gives one instruction per cycle, with imem_req continuously high.
  - Response accepted in cycle N is visible on if_id_* in cycle N+1.
- PC arithmetic: pc+1 is modulo 2^PC_W; PC_W'hFF+1 wraps to 0 with no flag.
- Stall with no response in flight: IF/ID and pc hold, and REQ keeps requesting the same address.
- Redirect:
  - Priority br_taken > jr > jump (older stage wins). Redirect overrides stall.
  - Same cycle: pc<=selected target, if_id_inst<=NOP_INST, if_id_valid<=0, buffer cleared, HOLD -> REQ.
  - If in REQ with imem_ready=0: discard<=1; the outstanding address is kept until ready, then dropped.
  - If in REQ with imem_ready=1: the response is dropped and the next request uses the target.
- Simultaneous redirect and imem_ready: redirect wins, and pc never takes pc+1 that cycle.
- if_id_pc1 of a bubble is don't-care but must be deterministic; it holds its previous value.

Optional Feature:
- FETCH_PERF_EN defined adds two outputs:
  - perf_fetched [15:0]: increments per accepted, non-discarded response.
  - perf_flushed [15:0]: increments per cycle in which a redirect squashes a valid IF/ID entry, buffer entry or in-flight request.
  - Both saturate at 16'hFFFF and are cleared by rst_n.
- Undefined: ports and counters are absent, with identical functional behaviour.

Test Plan:
- Reset release, imem_ready tied 1, rdata=addr-tagged (16'h1000+addr) -> if_id_valid first 1 on cycle 3, if_id_inst 1000,1001,1002 on consecutive cycles, if_id_pc1 1,2,3.
- imem_ready low 3 cycles at addr 5 -> imem_addr stays 5, if_id_valid holds last value, pc advances only after ready.
- stall=1 for 2 cycles while ready=1 at addr 7 -> instruction 1007 held in buffer, imem_req=0 in HOLD, 1007 appears on IF/ID the cycle after stall drops; no instruction lost or duplicated.
- br_taken=1 target 8'h40 with jump=1 target 8'h20 same cycle -> next imem_addr 40, if_id_inst=16'hF000, if_id_valid=0.
- jr target 8'h10 asserted while request to 9 outstanding (ready low) -> addr 9 held until ready, its data dropped, next request addr 10, first valid inst 1010.
- pc=8'hFF, ready=1 -> next imem_addr 00, if_id_pc1 00; with FETCH_PERF_EN, perf_fetched equals count of valid IF/ID loads.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register, PC / next-PC selection and imem handshake.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_flushed counters.
module fetch_stage #(
    parameter int                 PC_W     = 8,
    parameter int                 INST_W   = 16,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    parameter logic [INST_W-1:0]  NOP_INST = 16'hF000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    input  logic              jump,
    input  logic [PC_W-1:0]   jump_target,
    input  logic              jr,
    input  logic [PC_W-1:0]   jr_target,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_rdata,
`ifdef FETCH_PERF_EN
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_flushed,
`endif
    output logic [INST_W-1:0] if_id_inst,
    output logic [PC_W-1:0]   if_id_pc1,
    output logic              if_id_valid,
    output logic [3:0]        if_id_opcode
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t              state;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     pc_inc;
    logic [PC_W-1:0]     target;
    logic                redirect;
    logic                discard;
    logic                buf_valid;
    logic [INST_W-1:0]   buffer;

    assign pc_inc       = pc + PC_W'(1);
    assign if_id_opcode = if_id_inst[INST_W-1 -: 4];

    // Older stage wins: EX branch, then ID jr, then ID jump.
    always_comb begin
        redirect = br_taken | jr | jump;
        target   = jump_target;
        if (br_taken)
            target = br_target;
        else if (jr)
            target = jr_target;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            discard     <= 1'b0;
            buf_valid   <= 1'b0;
            buffer      <= NOP_INST;
            if_id_inst  <= NOP_INST;
            if_id_pc1   <= '0;
            if_id_valid <= 1'b0;
        end else if (redirect) begin
            pc          <= target;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
            buf_valid   <= 1'b0;
            state       <= REQ;
            imem_req    <= 1'b1;
            // An unanswered request must keep its address; its data is dropped on arrival.
            if (state == REQ && !imem_ready) begin
                discard <= 1'b1;
            end else begin
                discard   <= 1'b0;
                imem_addr <= target;
            end
        end else begin
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                REQ: begin
                    if (imem_ready) begin
                        if (discard) begin
                            discard   <= 1'b0;
                            imem_addr <= pc;
                        end else if (!stall) begin
                            if_id_inst  <= imem_rdata;
                            if_id_pc1   <= pc_inc;
                            if_id_valid <= 1'b1;
                            pc          <= pc_inc;
                            imem_addr   <= pc_inc;
                        end else begin
                            buffer    <= imem_rdata;
                            buf_valid <= 1'b1;
                            pc        <= pc_inc;
                            imem_addr <= pc_inc;
                            imem_req  <= 1'b0;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // pc already points past the buffered instruction, so it is its PC+1.
                    if (!stall) begin
                        if_id_inst  <= buffer;
                        if_id_pc1   <= pc;
                        if_id_valid <= buf_valid;
                        buf_valid   <= 1'b0;
                        state       <= REQ;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic accepted;
    logic squashed;

    assign accepted = (state == REQ) && imem_ready && !discard && !redirect;
    assign squashed = redirect && (if_id_valid || buf_valid || (state == REQ && !discard));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (accepted && perf_fetched != 16'hFFFF)
                perf_fetched <= perf_fetched + 16'd1;
            if (squashed && perf_flushed != 16'hFFFF)
                perf_flushed <= perf_flushed + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage: address-tagged memory (rdata = 16'h1000 + addr),
// one vector per clock, plus a hand-written mid-handshake reset sequence.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_taken, jump, jr;
    logic [7:0]  br_target, jump_target, jr_target;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] if_id_inst;
    logic [7:0]  if_id_pc1;
    logic        if_id_valid;
    logic [3:0]  if_id_opcode;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched, perf_flushed;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 16'h1000 + {8'h00, imem_addr};

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jump(jump), .jump_target(jump_target),
        .jr(jr), .jr_target(jr_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched), .perf_flushed(perf_flushed),
`endif
        .if_id_inst(if_id_inst), .if_id_pc1(if_id_pc1),
        .if_id_valid(if_id_valid), .if_id_opcode(if_id_opcode)
    );

    typedef struct {
        logic        stall, br, jump, jr, ready;
        logic [7:0]  brt, jt, jrt;
        logic        req;
        logic [7:0]  addr;
        logic        valid;
        logic [15:0] inst;
        logic [7:0]  pc1;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t mk(logic s, logic b, logic [7:0] bt, logic j, logic [7:0] jt,
                                logic r, logic [7:0] rt, logic rdy, logic req, logic [7:0] addr,
                                logic v, logic [15:0] inst, logic [7:0] pc1);
        vec_t t;
        t.stall = s; t.br = b; t.brt = bt; t.jump = j; t.jt = jt; t.jr = r; t.jrt = rt;
        t.ready = rdy; t.req = req; t.addr = addr; t.valid = v; t.inst = inst; t.pc1 = pc1;
        return t;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_outs(int idx, logic req, logic [7:0] addr, logic v,
                            logic [15:0] inst, logic [7:0] pc1);
        logic [15:0] op;
        op = inst;
        chk("imem_req", idx, 32'(imem_req), 32'(req));
        chk("imem_addr", idx, 32'(imem_addr), 32'(addr));
        chk("if_id_valid", idx, 32'(if_id_valid), 32'(v));
        chk("if_id_inst", idx, 32'(if_id_inst), 32'(inst));
        chk("if_id_pc1", idx, 32'(if_id_pc1), 32'(pc1));
        chk("if_id_opcode", idx, 32'(if_id_opcode), 32'(op[15:12]));
    endtask

    initial begin
        //               stall br brt   jmp jt    jr rt    rdy  req addr  v inst      pc1
        tbl[0]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h00, 0, 16'hF000, 8'h00);
        tbl[1]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h01, 1, 16'h1000, 8'h01);
        tbl[2]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h02, 1, 16'h1001, 8'h02);
        tbl[3]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h03, 1, 16'h1002, 8'h03);
        tbl[4]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h04, 1, 16'h1003, 8'h04);
        tbl[5]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h05, 1, 16'h1004, 8'h05);
        tbl[6]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0,  1, 8'h05, 1, 16'h1004, 8'h05);
        tbl[7]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0,  1, 8'h05, 1, 16'h1004, 8'h05);
        tbl[8]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0,  1, 8'h05, 1, 16'h1004, 8'h05);
        tbl[9]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h06, 1, 16'h1005, 8'h06);
        tbl[10] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h07, 1, 16'h1006, 8'h07);
        tbl[11] = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  0, 8'h08, 1, 16'h1006, 8'h07);
        tbl[12] = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  0, 8'h08, 1, 16'h1006, 8'h07);
        tbl[13] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h08, 1, 16'h1007, 8'h08);
        tbl[14] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h09, 1, 16'h1008, 8'h09);
        tbl[15] = mk(0, 0, 8'h00, 0, 8'h00, 1, 8'h10, 0,  1, 8'h09, 0, 16'hF000, 8'h09);
        tbl[16] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0,  1, 8'h09, 0, 16'hF000, 8'h09);
        tbl[17] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h10, 0, 16'hF000, 8'h09);
        tbl[18] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h11, 1, 16'h1010, 8'h11);
        tbl[19] = mk(0, 1, 8'h40, 1, 8'h20, 0, 8'h00, 1,  1, 8'h40, 0, 16'hF000, 8'h11);
        tbl[20] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h41, 1, 16'h1040, 8'h41);
        tbl[21] = mk(1, 0, 8'h00, 1, 8'h30, 1, 8'hFE, 1,  1, 8'hFE, 0, 16'hF000, 8'h41);
        tbl[22] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'hFF, 1, 16'h10FE, 8'hFF);
        tbl[23] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h00, 1, 16'h10FF, 8'h00);
        tbl[24] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h01, 1, 16'h1000, 8'h01);
        tbl[25] = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0,  1, 8'h01, 1, 16'h1000, 8'h01);
        tbl[26] = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  0, 8'h02, 1, 16'h1000, 8'h01);
        tbl[27] = mk(1, 0, 8'h00, 1, 8'h50, 0, 8'h00, 1,  1, 8'h50, 0, 16'hF000, 8'h01);
        tbl[28] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1,  1, 8'h51, 1, 16'h1050, 8'h51);

        rst_n = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        br_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        br_target = '0; jump_target = '0; jr_target = '0;
        repeat (2) @(posedge clk);
        #1 chk_outs(-1, 1'b0, 8'h00, 1'b0, 16'hF000, 8'h00);
`ifdef FETCH_PERF_EN
        chk("perf_fetched_rst", -1, 32'(perf_fetched), 32'd0);
`endif

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 29; i++) begin
            stall = tbl[i].stall; imem_ready = tbl[i].ready;
            br_taken = tbl[i].br; br_target = tbl[i].brt;
            jump = tbl[i].jump;   jump_target = tbl[i].jt;
            jr = tbl[i].jr;       jr_target = tbl[i].jrt;
            @(posedge clk);
            #1 chk_outs(i, tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].inst, tbl[i].pc1);
            @(negedge clk);
        end

`ifdef FETCH_PERF_EN
        chk("perf_fetched", 29, 32'(perf_fetched), 32'd16);
        chk("perf_flushed", 29, 32'(perf_flushed), 32'd4);
`endif

        // Reset while request to 0x51 is unanswered: it is abandoned, and ready in IDLE is ignored.
        stall = 1'b0; br_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        imem_ready = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        #1 chk_outs(100, 1'b0, 8'h00, 1'b0, 16'hF000, 8'h00);
        @(negedge clk);
        rst_n = 1'b1; imem_ready = 1'b1;
        @(posedge clk);
        #1 chk_outs(101, 1'b1, 8'h00, 1'b0, 16'hF000, 8'h00);
        @(negedge clk);
        @(posedge clk);
        #1 chk_outs(102, 1'b1, 8'h01, 1'b1, 16'h1000, 8'h01);
`ifdef FETCH_PERF_EN
        chk("perf_fetched_post", 102, 32'(perf_fetched), 32'd1);
        chk("perf_flushed_post", 102, 32'(perf_flushed), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
